// File: rtl/alu_ctrl.sv
// alu_ctrl: IDLE/RD_A/RD_B/EXEC/WB sequencer for the OrgaSmall ALU, register file and Z/C/N flags.
// Optional macro ALU_CTRL_PIPE_EN: accept the next command during WB (one command per 4 cycles).
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

package alu_ctrl_pkg;
    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_ADC = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_CMP = 4'd6,
        OP_SHL = 4'd7,
        OP_SHR = 4'd8,
        OP_INC = 4'd9,
        OP_DEC = 4'd10
    } opcode_t;
endpackage

module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WORD_SIZE  = `WORD_SIZE,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  opcode_t               cmd_op,
    input  logic [REG_ADDR_W-1:0] cmd_rx,
    input  logic [REG_ADDR_W-1:0] cmd_ry,
    output logic [REG_ADDR_W-1:0] rf_raddr,
    input  logic [WORD_SIZE-1:0]  rf_rdata,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [WORD_SIZE-1:0]  rf_wdata,
    output logic [WORD_SIZE-1:0]  alu_a,
    output logic [WORD_SIZE-1:0]  alu_b,
    output opcode_t               alu_opcode,
    input  logic [WORD_SIZE-1:0]  alu_out,
    output logic                  flag_z,
    output logic                  flag_c,
    output logic                  flag_n,
    output logic                  done
);
    typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB} state_t;

    state_t                r_state;
    opcode_t               r_op;
    logic [REG_ADDR_W-1:0] r_rx;
    logic [REG_ADDR_W-1:0] r_ry;
    logic [REG_ADDR_W-1:0] r_raddr;
    logic [REG_ADDR_W-1:0] r_waddr;
    logic [WORD_SIZE-1:0]  r_opa;
    logic [WORD_SIZE-1:0]  r_wdata;
    logic                  r_we;
    logic                  r_done;
    logic                  r_flagZ;
    logic                  r_flagC;
    logic                  r_flagN;
    logic                  r_nextZ;
    logic                  r_nextC;
    logic                  r_nextN;

    logic                  w_readyState;
    logic                  w_accept;
    logic [WORD_SIZE-1:0]  w_opb;
    logic [WORD_SIZE-1:0]  w_result;
    logic [WORD_SIZE:0]    w_sum;
    logic                  w_write;
    logic                  w_z;
    logic                  w_c;
    logic                  w_n;

`ifdef ALU_CTRL_PIPE_EN
    assign w_readyState = (r_state == IDLE) || (r_state == WB);
`else
    assign w_readyState = (r_state == IDLE);
`endif

    assign cmd_ready = w_readyState && !rst;
    assign w_accept  = cmd_valid && cmd_ready;

    // The second operand's read data only arrives during EXEC, so opb feeds the ALU directly.
    assign w_opb      = (r_op == OP_INC || r_op == OP_DEC) ? '0 : rf_rdata;
    assign alu_a      = (r_state == EXEC) ? r_opa : '0;
    assign alu_b      = (r_state == EXEC) ? w_opb : '0;
    assign alu_opcode = (r_state == EXEC) ? r_op : OP_ADD;

    always_comb begin
        w_sum    = {1'b0, r_opa} + {1'b0, w_opb};
        w_result = alu_out;
        w_write  = 1'b1;
        w_c      = 1'b0;
        w_z      = 1'b0;
        w_n      = 1'b0;
        case (r_op)
            OP_ADD: w_c = w_sum[WORD_SIZE];
            OP_ADC: begin
                w_sum    = w_sum + {{WORD_SIZE{1'b0}}, r_flagC};
                w_result = alu_out + {{(WORD_SIZE-1){1'b0}}, r_flagC};
                w_c      = w_sum[WORD_SIZE];
            end
            OP_SUB: w_c = (r_opa < w_opb);
            OP_INC: w_c = (r_opa == '1);
            OP_DEC: w_c = (r_opa == '0);
            OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: w_c = 1'b0;
            OP_CMP: begin
                w_write = 1'b0;
                w_c     = (r_opa < w_opb);
            end
            default: w_result = '0;
        endcase
        if (r_op == OP_CMP) begin
            w_z = alu_out[0];
            w_n = 1'b0;
        end else begin
            w_z = (w_result == '0);
            w_n = w_result[WORD_SIZE-1];
        end
    end

    // Flags are staged at the end of EXEC and only become architectural when WB completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= OP_ADD;
            r_rx    <= '0;
            r_ry    <= '0;
            r_raddr <= '0;
            r_waddr <= '0;
            r_opa   <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_flagZ <= 1'b0;
            r_flagC <= 1'b0;
            r_flagN <= 1'b0;
            r_nextZ <= 1'b0;
            r_nextC <= 1'b0;
            r_nextN <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op    <= cmd_op;
                        r_rx    <= cmd_rx;
                        r_ry    <= cmd_ry;
                        r_raddr <= cmd_rx;
                        r_state <= RD_A;
                    end
                end
                RD_A: begin
                    r_raddr <= r_ry;
                    r_state <= RD_B;
                end
                RD_B: begin
                    r_opa   <= rf_rdata;
                    r_state <= EXEC;
                end
                EXEC: begin
                    r_wdata <= w_result;
                    r_waddr <= r_rx;
                    r_we    <= w_write;
                    r_done  <= 1'b1;
                    r_nextZ <= w_z;
                    r_nextC <= w_c;
                    r_nextN <= w_n;
                    r_state <= WB;
                end
                WB: begin
                    r_flagZ <= r_nextZ;
                    r_flagC <= r_nextC;
                    r_flagN <= r_nextN;
                    r_state <= IDLE;
                    if (w_accept) begin
                        r_op    <= cmd_op;
                        r_rx    <= cmd_rx;
                        r_ry    <= cmd_ry;
                        r_raddr <= cmd_rx;
                        r_state <= RD_A;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rf_raddr = r_raddr;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;
    assign rf_we    = r_we && !rst;
    assign done     = r_done && !rst;
    assign flag_z   = r_flagZ;
    assign flag_c   = r_flagC;
    assign flag_n   = r_flagN;

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: drives alu_ctrl against a behavioural register file and ALU, with a retire scoreboard.
// Vectors chain the carry flag from one entry to the next, so table order matters.
module tb_alu_ctrl;
    import alu_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    opcode_t    cmd_op;
    logic [2:0] cmd_rx;
    logic [2:0] cmd_ry;
    logic [2:0] rf_raddr;
    logic [7:0] rf_rdata;
    logic       rf_we;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    opcode_t    alu_opcode;
    logic [7:0] alu_out;
    logic       flag_z;
    logic       flag_c;
    logic       flag_n;
    logic       done;

    alu_ctrl #(.WORD_SIZE(8), .REG_ADDR_W(3)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rx(cmd_rx), .cmd_ry(cmd_ry),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
        .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .done(done)
    );

    always #5 clk = ~clk;

`ifdef ALU_CTRL_PIPE_EN
    localparam int RETIRE_GAP = 4;
`else
    localparam int RETIRE_GAP = 5;
`endif

    typedef struct {
        opcode_t    op;
        logic [2:0] rx;
        logic [2:0] ry;
        logic [7:0] aVal;
        logic [7:0] bVal;
        logic [7:0] expRes;
        logic       expWe;
        logic       expZ;
        logic       expC;
        logic       expN;
    } vec_t;

    typedef struct {
        logic [2:0] rx;
        logic [7:0] expRes;
        logic       expWe;
        logic       expZ;
        logic       expC;
        logic       expN;
        int         acceptCycle;
    } sb_t;

    int   errorCount = 0;
    int   checkCount = 0;
    int   cycleCount = 0;
    sb_t  sbQueue[$];
    sb_t  lastExp;
    logic flagPending = 1'b0;
    int   retireCycles[$];

    logic [7:0] regs [8];
    logic       preWe = 1'b0;
    logic [2:0] preAddr = 3'd0;
    logic [7:0] preData = 8'd0;

    // Register file with a one-cycle synchronous read; the bench preloads through its own port.
    always @(posedge clk) begin
        cycleCount <= cycleCount + 1;
        rf_rdata   <= regs[rf_raddr];
        if (rf_we) regs[rf_waddr] <= rf_wdata;
        if (preWe) regs[preAddr] <= preData;
    end

    // Reference ALU; an unknown opcode returns junk that the controller must discard.
    always_comb begin
        case (alu_opcode)
            OP_ADD, OP_ADC: alu_out = alu_a + alu_b;
            OP_SUB:         alu_out = alu_a - alu_b;
            OP_AND:         alu_out = alu_a & alu_b;
            OP_OR:          alu_out = alu_a | alu_b;
            OP_XOR:         alu_out = alu_a ^ alu_b;
            OP_CMP:         alu_out = (alu_a == alu_b) ? 8'd1 : 8'd0;
            OP_SHL:         alu_out = alu_a << alu_b;
            OP_SHR:         alu_out = alu_a >> alu_b;
            OP_INC:         alu_out = alu_a + 8'd1;
            OP_DEC:         alu_out = alu_a - 8'd1;
            default:        alu_out = 8'hA5;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCount);
        end
    endtask

    // Retire monitor: done/rf_we are compared when they appear, flags one cycle later after commit.
    always @(negedge clk) begin
        if (flagPending) begin
            checkOutput("flag_z", flag_z, lastExp.expZ);
            checkOutput("flag_c", flag_c, lastExp.expC);
            checkOutput("flag_n", flag_n, lastExp.expN);
            checkOutput("done single pulse", done, 1'b0);
            flagPending = 1'b0;
        end
        if (!rst && (alu_opcode == OP_INC || alu_opcode == OP_DEC))
            checkOutput("alu_b forced zero", alu_b, 8'h00);
        if (!rst && (done || rf_we)) begin
            if (sbQueue.size() == 0) begin
                checkCount++;
                errorCount++;
                $display("[TB] FAIL unexpected retire: done=%0b rf_we=%0b waddr=%0d, required no activity",
                         done, rf_we, rf_waddr);
            end else begin
                lastExp = sbQueue.pop_front();
                checkOutput("done", done, 1'b1);
                checkOutput("rf_we", rf_we, lastExp.expWe);
                if (lastExp.expWe) begin
                    checkOutput("rf_waddr", rf_waddr, lastExp.rx);
                    checkOutput("rf_wdata", rf_wdata, lastExp.expRes);
                end
                // Accept edge T puts WB in the cycle after edge T+3, i.e. cycle T+4.
                checkOutput("retire latency", cycleCount - lastExp.acceptCycle, 3);
                retireCycles.push_back(cycleCount);
                flagPending = 1'b1;
            end
        end
    end

    task automatic preload(input logic [2:0] addr, input logic [7:0] data);
        preWe   = 1'b1;
        preAddr = addr;
        preData = data;
        @(negedge clk);
        preWe   = 1'b0;
    endtask

    // Called just after a negedge; returns one negedge after the accepting edge.
    task automatic applyStimulus(input opcode_t op, input logic [2:0] rx, input logic [2:0] ry,
                                 input logic [7:0] expRes, input logic expWe,
                                 input logic expZ, input logic expC, input logic expN);
        sb_t e;
        int  n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rx    = rx;
        cmd_ry    = ry;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL accept timeout: cmd_ready=%0b, required 1 within 20 cycles", cmd_ready);
        end else begin
            e.rx = rx; e.expRes = expRes; e.expWe = expWe;
            e.expZ = expZ; e.expC = expC; e.expN = expN;
            e.acceptCycle = cycleCount + 1;
            sbQueue.push_back(e);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        #1;
        while ((sbQueue.size() != 0 || flagPending) && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 40) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL retire timeout: %0d commands still pending, required 0", sbQueue.size());
            sbQueue.delete();
            flagPending = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    vec_t vecs[21];

    initial begin
        vecs[0]  = '{OP_ADD, 3'd1, 3'd2, 8'h7F, 8'h81, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{OP_ADC, 3'd3, 3'd4, 8'h10, 8'h20, 8'h31, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{OP_ADD, 3'd1, 3'd2, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{OP_ADC, 3'd3, 3'd4, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{OP_SUB, 3'd1, 3'd2, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{OP_DEC, 3'd0, 3'd2, 8'h00, 8'h55, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{OP_CMP, 3'd5, 3'd6, 8'h42, 8'h42, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{OP_CMP, 3'd5, 3'd6, 8'h10, 8'h20, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{OP_AND, 3'd1, 3'd2, 8'hF0, 8'h3C, 8'h30, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{OP_OR,  3'd1, 3'd2, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{OP_XOR, 3'd3, 3'd4, 8'hAA, 8'h55, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{OP_SHL, 3'd1, 3'd2, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{OP_SHL, 3'd1, 3'd2, 8'h01, 8'h08, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{OP_SHR, 3'd1, 3'd2, 8'h80, 8'h07, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{OP_INC, 3'd7, 3'd2, 8'hFF, 8'h33, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{OP_INC, 3'd1, 3'd2, 8'h7F, 8'h33, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{opcode_t'(4'hF), 3'd2, 3'd3, 8'h12, 8'h34, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{OP_ADD, 3'd4, 3'd4, 8'h40, 8'h40, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{OP_ADC, 3'd1, 3'd2, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[19] = '{OP_DEC, 3'd2, 3'd3, 8'h01, 8'h77, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[20] = '{OP_SUB, 3'd1, 3'd2, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_ADD;
        cmd_rx    = 3'd0;
        cmd_ry    = 3'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset cmd_ready", cmd_ready, 1'b0);
        checkOutput("reset done", done, 1'b0);
        checkOutput("reset rf_we", rf_we, 1'b0);
        checkOutput("reset flags", {flag_z, flag_c, flag_n}, 3'b000);
        checkOutput("reset alu_a", alu_a, 8'h00);
        checkOutput("reset alu_b", alu_b, 8'h00);
        checkOutput("reset alu_opcode", alu_opcode, OP_ADD);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready after reset", cmd_ready, 1'b1);

        for (int i = 0; i < 21; i++) begin
            preload(vecs[i].rx, vecs[i].aVal);
            preload(vecs[i].ry, vecs[i].bVal);
            applyStimulus(vecs[i].op, vecs[i].rx, vecs[i].ry, vecs[i].expRes,
                          vecs[i].expWe, vecs[i].expZ, vecs[i].expC, vecs[i].expN);
            waitIdle();
            if (vecs[i].expWe) checkOutput($sformatf("regfile v%0d", i), regs[vecs[i].rx], vecs[i].expRes);
            else               checkOutput($sformatf("regfile kept v%0d", i), regs[vecs[i].rx], vecs[i].aVal);
        end

        // Reset during EXEC: set flags first, then abort an ADD and keep offering another command.
        preload(3'd1, 8'h7F);
        preload(3'd2, 8'h81);
        preload(3'd6, 8'h66);
        applyStimulus(OP_ADD, 3'd1, 3'd2, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        waitIdle();
        preload(3'd1, 8'h01);
        preload(3'd2, 8'h01);
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
        cmd_rx    = 3'd1;
        cmd_ry    = 3'd2;
        checkOutput("abort cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_rx = 3'd6;
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst high cmd_ready", cmd_ready, 1'b0);
        checkOutput("rst high rf_we", rf_we, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready after abort", cmd_ready, 1'b1);
        checkOutput("flags after abort", {flag_z, flag_c, flag_n}, 3'b000);
        repeat (6) @(negedge clk);
        checkOutput("aborted R1 unchanged", regs[1], 8'h01);
        checkOutput("held cmd R6 unchanged", regs[6], 8'h66);

        // Two INCs with cmd_valid held across the first command.
        preload(3'd1, 8'h01);
        preload(3'd2, 8'h00);
        retireCycles.delete();
        applyStimulus(OP_INC, 3'd1, 3'd2, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(OP_INC, 3'd1, 3'd2, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
        waitIdle();
        checkOutput("back-to-back retires", retireCycles.size(), 2);
        if (retireCycles.size() == 2)
            checkOutput("retire spacing", retireCycles[1] - retireCycles[0], RETIRE_GAP);
        checkOutput("R1 after two INC", regs[1], 8'h03);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule
